proc_control_unit: RTL
======================

Name: proc_control_unit

Overview:
Control unit for the six-instruction 16-bit processor. It fetches instructions from instruction memory, holds the PC and the instruction register, and sequences a Moore FSM. The FSM drives the register file ports (write address, write enable, read addresses A/B), the data-memory address and write strobe, the register-file write-data mux and the ALU function select.

Parameters:
PC_W, 7, program counter width; instruction memory depth is 2^PC_W
DADDR_W, 8, data memory address width; taken from IR[DADDR_W-1:0]

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
im_data  in  16  instruction memory read data; asynchronous read of im_addr
im_addr  out  PC_W  current PC
d_addr  out  DADDR_W  data memory address
d_wr  out  1  data memory write strobe; memory writes rdDataA
rf_sel  out  1  register-file write-data mux: 1 = data memory read data, 0 = ALU result
rf_w_addr  out  4  register file write address
rf_w_wr  out  1  register file write enable
rf_ra_addr  out  4  register file read address A
rf_rb_addr  out  4  register file read address B
alu_sel  out  2  ALU function: 00 pass A, 01 A+B, 10 A-B
halted  out  1  high while in the HALT state
illegal  out  1  illegal opcode flag; tied 0 unless the macro is defined

Behaviour:
- Instruction fields: op = IR[15:12], ra = IR[11:8], rb = IR[7:4], rq = IR[3:0], addr = IR[DADDR_W-1:0].
- Opcodes: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT.
- Reset: state = INIT, PC = 0, IR = 0. Every output except im_addr is forced to 0 while reset is high, including mid-instruction, so a reset during LOAD_B or STORE produces no write.
- INIT: clear PC; next state FETCH.
- FETCH: IR <= im_data; PC <= PC+1, wrapping modulo 2^PC_W; next state DECODE.
- DECODE: no strobes asserted; dispatch on op. Opcodes 6-15 go to NOOP when the macro is absent.
- NOOP: next state FETCH.
- STORE: d_addr = addr, rf_ra_addr = ra, d_wr = 1 for exactly one cycle; next state FETCH.
- LOAD_A: d_addr = addr, rf_sel = 1, rf_w_addr = ra, rf_w_wr = 0; next state LOAD_B. This cycle covers the data memory's one-cycle synchronous read.
- LOAD_B: same outputs as LOAD_A with rf_w_wr = 1; next state FETCH.
- ADD and SUB: rf_ra_addr = ra, rf_rb_addr = rb, rf_w_addr = rq, rf_sel = 0, rf_w_wr = 1; alu_sel = 01 for ADD, 10 for SUB; next state FETCH.
- HALT: halted = 1; the state is held and PC/IR are frozen; only reset exits.
- Outputs are decoded combinationally from state and IR. Any output not listed for a state is 0.
- Cycles per instruction, counted from FETCH: NOOP/STORE/ADD/SUB 3, LOAD 4.
- PC wrap: instruction at 2^PC_W-1 is followed by address 0, with no flag.

Optional Feature:
PROC_CTRL_ILLEGAL_TRAP_EN
- Defined: opcodes 6-15 in DECODE go to HALT and set illegal = 1. illegal is a sticky register cleared only by reset, and halted = 1 as well.
- Undefined: opcodes 6-15 execute as NOOP and illegal is constant 0.

Decomposition:
- Package proc_ctrl_pkg:
  - state enum: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT
  - opcode enum
  - ALU_PASS / ALU_ADD / ALU_SUB constants
  - field bit-position localparams
- Sub-module pc_counter (parameter PC_W):
  - inputs: clear, inc
  - output: pc
  - synchronous reset to 0

Test Plan:
- Reset, then im[0] = 16'h3123 -> INIT, FETCH, DECODE, then ADD cycle with rf_ra_addr=1, rf_rb_addr=2, rf_w_addr=3, rf_w_wr=1, alu_sel=01, rf_sel=0; im_addr=1 at DECODE.
- im = 16'h2A05 -> LOAD_A: d_addr=8'h05, rf_sel=1, rf_w_addr=A, rf_w_wr=0; LOAD_B: rf_w_wr=1 for exactly one cycle; FETCH follows.
- im = 16'h1740 -> d_wr=1 for exactly one cycle, d_addr=8'h40, rf_ra_addr=7, rf_w_wr=0 throughout.
- im = 16'h5000 -> halted=1 held for 20 cycles, im_addr constant, no strobes; then reset pulse -> halted=0 and im_addr=0 on the following cycle.
- 128 consecutive NOOPs (16'h0000) with PC_W=7 -> im_addr steps 0..127 then wraps to 0. Reset asserted in a LOAD_B cycle -> rf_w_wr=0 in that cycle, INIT next.
- im = 16'hF000 -> macro undefined: 3-cycle NOOP, illegal=0; macro defined: halted=1 and illegal=1, both held until reset.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the six-instruction processor control unit.
package proc_ctrl_pkg;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned ALU_SEL_W  = 2;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RA_MSB = 11;
  localparam int unsigned RA_LSB = 8;
  localparam int unsigned RB_MSB = 7;
  localparam int unsigned RB_LSB = 4;
  localparam int unsigned RQ_MSB = 3;
  localparam int unsigned RQ_LSB = 0;

  typedef enum logic [3:0] {
    INIT,
    FETCH,
    DECODE,
    NOOP,
    LOAD_A,
    LOAD_B,
    STORE,
    ADD,
    SUB,
    HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  localparam logic [ALU_SEL_W-1:0] ALU_PASS = 2'b00;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 2'b01;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/proc_control_unit_if.sv
// Control-unit bus: instruction fetch, data memory, register file and ALU controls.
interface proc_control_unit_if
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = 7,
  parameter int unsigned DADDR_W = 8
);

  logic [INSTR_W-1:0]    im_data;
  logic [PC_W-1:0]       im_addr;
  logic [DADDR_W-1:0]    d_addr;
  logic                  d_wr;
  logic                  rf_sel;
  logic [REG_ADDR_W-1:0] rf_w_addr;
  logic                  rf_w_wr;
  logic [REG_ADDR_W-1:0] rf_ra_addr;
  logic [REG_ADDR_W-1:0] rf_rb_addr;
  logic [ALU_SEL_W-1:0]  alu_sel;
  logic                  halted;
  logic                  illegal;

  modport master (
    input  im_data,
    output im_addr, d_addr, d_wr, rf_sel, rf_w_addr, rf_w_wr,
           rf_ra_addr, rf_rb_addr, alu_sel, halted, illegal
  );

  modport slave (
    output im_data,
    input  im_addr, d_addr, d_wr, rf_sel, rf_w_addr, rf_w_wr,
           rf_ra_addr, rf_rb_addr, alu_sel, halted, illegal
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter: synchronous clear, increment wraps modulo 2^PC_W.
module pc_counter #(
  parameter int unsigned PC_W = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/proc_control_unit.sv
// Moore-FSM control unit: fetch, decode and sequence the six-instruction processor.
// Define PROC_CTRL_ILLEGAL_TRAP_EN to trap opcodes 6-15 into HALT with a sticky illegal flag.
module proc_control_unit
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = 7,
  parameter int unsigned DADDR_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  proc_control_unit_if.master bus
);

  state_t                state;
  state_t                state_nxt;
  logic [INSTR_W-1:0]    ir;
  logic [PC_W-1:0]       pc;
  logic                  pc_clear;
  logic                  pc_inc;
  logic                  illegal_flag;
  opcode_t               op;
  logic [REG_ADDR_W-1:0] fld_ra;
  logic [REG_ADDR_W-1:0] fld_rb;
  logic [REG_ADDR_W-1:0] fld_rq;
  logic [DADDR_W-1:0]    fld_addr;

  logic [DADDR_W-1:0]    d_addr_c;
  logic                  d_wr_c;
  logic                  rf_sel_c;
  logic [REG_ADDR_W-1:0] rf_w_addr_c;
  logic                  rf_w_wr_c;
  logic [REG_ADDR_W-1:0] rf_ra_addr_c;
  logic [REG_ADDR_W-1:0] rf_rb_addr_c;
  logic [ALU_SEL_W-1:0]  alu_sel_c;
  logic                  halted_c;

  assign op       = opcode_t'(ir[OP_MSB:OP_LSB]);
  assign fld_ra   = ir[RA_MSB:RA_LSB];
  assign fld_rb   = ir[RB_MSB:RB_LSB];
  assign fld_rq   = ir[RQ_MSB:RQ_LSB];
  assign fld_addr = ir[DADDR_W-1:0];

  pc_counter #(.PC_W(PC_W)) u_pc (
    .clock (clock),
    .reset (reset),
    .clear (pc_clear),
    .inc   (pc_inc),
    .pc    (pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) begin
        ir <= bus.im_data;
      end
    end
  end

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  // Sticky: set when DECODE sees an opcode beyond HALT, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_flag <= 1'b0;
    end else if ((state == DECODE) && (ir[OP_MSB:OP_LSB] > 4'(OP_HALT))) begin
      illegal_flag <= 1'b1;
    end
  end
`else
  assign illegal_flag = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    pc_clear     = 1'b0;
    pc_inc       = 1'b0;
    d_addr_c     = '0;
    d_wr_c       = 1'b0;
    rf_sel_c     = 1'b0;
    rf_w_addr_c  = '0;
    rf_w_wr_c    = 1'b0;
    rf_ra_addr_c = '0;
    rf_rb_addr_c = '0;
    alu_sel_c    = ALU_PASS;
    halted_c     = 1'b0;

    case (state)
      INIT: begin
        pc_clear  = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        pc_inc    = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        case (op)
          OP_NOOP:  state_nxt = NOOP;
          OP_STORE: state_nxt = STORE;
          OP_LOAD:  state_nxt = LOAD_A;
          OP_ADD:   state_nxt = ADD;
          OP_SUB:   state_nxt = SUB;
          OP_HALT:  state_nxt = HALT;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
          default:  state_nxt = HALT;
`else
          default:  state_nxt = NOOP;
`endif
        endcase
      end
      NOOP: state_nxt = FETCH;
      STORE: begin
        d_addr_c     = fld_addr;
        rf_ra_addr_c = fld_ra;
        d_wr_c       = 1'b1;
        state_nxt    = FETCH;
      end
      // LOAD_A spans the data memory's synchronous read; LOAD_B commits it.
      LOAD_A, LOAD_B: begin
        d_addr_c    = fld_addr;
        rf_sel_c    = 1'b1;
        rf_w_addr_c = fld_ra;
        rf_w_wr_c   = (state == LOAD_B);
        state_nxt   = (state == LOAD_A) ? LOAD_B : FETCH;
      end
      ADD, SUB: begin
        rf_ra_addr_c = fld_ra;
        rf_rb_addr_c = fld_rb;
        rf_w_addr_c  = fld_rq;
        rf_w_wr_c    = 1'b1;
        alu_sel_c    = (state == ADD) ? ALU_ADD : ALU_SUB;
        state_nxt    = FETCH;
      end
      HALT: begin
        halted_c  = 1'b1;
        state_nxt = HALT;
      end
      default: state_nxt = INIT;
    endcase

    // Reset silences every strobe immediately, even mid-instruction.
    if (reset) begin
      d_addr_c     = '0;
      d_wr_c       = 1'b0;
      rf_sel_c     = 1'b0;
      rf_w_addr_c  = '0;
      rf_w_wr_c    = 1'b0;
      rf_ra_addr_c = '0;
      rf_rb_addr_c = '0;
      alu_sel_c    = ALU_PASS;
      halted_c     = 1'b0;
    end
  end

  assign bus.im_addr    = pc;
  assign bus.d_addr     = d_addr_c;
  assign bus.d_wr       = d_wr_c;
  assign bus.rf_sel     = rf_sel_c;
  assign bus.rf_w_addr  = rf_w_addr_c;
  assign bus.rf_w_wr    = rf_w_wr_c;
  assign bus.rf_ra_addr = rf_ra_addr_c;
  assign bus.rf_rb_addr = rf_rb_addr_c;
  assign bus.alu_sel    = alu_sel_c;
  assign bus.halted     = halted_c;
  assign bus.illegal    = illegal_flag & ~reset;

endmodule
